arg_max_frame: RTL
==================

Name: arg_max_frame

Overview:
- Streaming complex-sample argmax for the CAF peak search.
- Accepts I/Q samples, forms the power |x|^2 = I^2 + Q^2, and tracks the maximum power and its index over fixed frames of LENGTH samples.
- Emits one (out_max, index) result per frame.
- Successor to the single-shot argmax: parametrised frame length, frame-relative indexing, buffered results under output backpressure, and an optional threshold detect.

Parameters:
- I_BITS, 12, signed I sample width
- Q_BITS, 12, signed Q sample width
- LENGTH, 1024, samples per frame; must be >= 4
- INDEX_BITS, $clog2(LENGTH), index width
- OUT_MAX_BITS, 2*max(I_BITS,Q_BITS), unsigned power width; holds the worst case 2^(2n-1) exactly

Ports:
- clk  input  1  clock
- n_rst  input  1  synchronous active-low reset
- xi  input  I_BITS  signed in-phase sample
- xq  input  Q_BITS  signed quadrature sample
- m_axis_tvalid  input  1  upstream sample valid
- s_axis_tready  output  1  block ready for a sample
- s_axis_tvalid  output  1  result valid
- m_axis_tready  input  1  downstream accepts result
- out_max  output  OUT_MAX_BITS  peak power of the frame
- index  output  INDEX_BITS  0-based sample position of the peak within its frame

Behaviour:
- Reset (n_rst=0 at posedge clk):
  - s_axis_tvalid=0, out_max=0, index=0, s_axis_tready=0.
  - Sample counter, pipeline valids, running max and pending buffer are cleared.
  - s_axis_tready rises on the first clock edge after n_rst returns to 1.
  - Reset mid-frame discards the partial frame and any unsent results.
- Sample acceptance: a sample transfers on a posedge with m_axis_tvalid && s_axis_tready. Samples presented while s_axis_tready=0 are not consumed.
- Pipeline:
  - S1 registers the sign-extended xi^2 + xq^2 with a valid bit.
  - S2 compares against the running max.
  - Stages advance unconditionally; bubbles carry valid=0.
- Running max:
  - The first sample of each frame loads max and index unconditionally.
  - Later samples replace the running value only if power > max (strict); ties keep the earliest index.
  - The index counter runs 0..LENGTH-1 and wraps to 0 after the last sample. The next frame starts with no gap.
- Frame completion: when S2 processes index LENGTH-1, the final (max, index) is written to:
  - the output register, if it is empty or is handshaking this cycle; or
  - otherwise the single pending register.
- Latency: last sample accepted at edge t gives s_axis_tvalid=1 after edge t+2 (output register empty).
- Output handshake:
  - s_axis_tvalid stays high and out_max/index stay stable until m_axis_tready=1 at a posedge.
  - On that edge the pending entry (if any) moves to the output register, so s_axis_tvalid remains 1 with new data. Otherwise s_axis_tvalid goes to 0.
  - A frame completion on the same edge as an output handshake with pending empty loads the output register directly; no bubble.
- Input backpressure:
  - s_axis_tready is registered. It is 0 while the pending register is occupied and 1 otherwise.
  - At most 2 in-flight samples can complete after pending fills. LENGTH >= 4 guarantees no third frame completes, so no result is ever dropped.
- Arithmetic: the squares are exact, the sum is exact and unsigned, with no saturation.

Optional Feature:
- Macro: ARG_MAX_THRESHOLD_EN.
- When defined, add:
  - input threshold (OUT_MAX_BITS, unsigned, sampled when the result is written);
  - output detect (1), registered alongside out_max with the same valid/hold rules; detect = out_max > threshold (strict).
  - Reset: detect=0.
- When undefined, neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared package arg_max_pkg holds:
  - localparam helpers for OUT_MAX_BITS and INDEX_BITS computation;
  - a result struct/typedef {out_max, index, detect} used by the output and pending registers.
- One natural sub-module, arg_max_power: pipelined I^2+Q^2 (S1 stage with valid). It is reusable by the CAF magnitude stage.

Test Plan:
- LENGTH=8, m_axis_tready=1, powers {1,4,9,100,9,4,1,0} (e.g. xi=10,xq=0 at idx3) -> out_max=100, index=3, s_axis_tvalid high exactly 1 cycle, 2 cycles after the last accept.
- Tie: LENGTH=8, samples (3,4) at idx2 and (4,3) at idx6, all others 0 -> out_max=25, index=2.
- Extremes: I_BITS=Q_BITS=12, xi=xq=-2048 at idx0 -> out_max=8388608 (2^23), no overflow.
- Backpressure: LENGTH=4, m_axis_tready=0, 3 frames streamed continuously:
  - s_axis_tvalid holds frame0 result;
  - s_axis_tready drops after frame1 completes;
  - releasing m_axis_tready delivers frame0, frame1, frame2 in order, with none lost.
- Reset mid-frame: n_rst=0 at sample 5 of 8, then a full fresh frame -> only the fresh frame's result appears, index relative to its first sample.
- With ARG_MAX_THRESHOLD_EN, threshold=50: frame peak 100 -> detect=1; frame peak 50 -> detect=0.

Source files
------------

// File: rtl/arg_max_pkg.sv
// Shared width helpers for the frame argmax block and its power stage.
package arg_max_pkg;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int out_max_w(input int i_bits, input int q_bits);
    return 2 * max_w(i_bits, q_bits);
  endfunction

  function automatic int index_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/arg_max_power.sv
// Pipelined |x|^2 = I^2 + Q^2 stage with a valid bit.
// Exact for any signed I/Q when P_BITS = 2*max(I_BITS,Q_BITS).
module arg_max_power
  import arg_max_pkg::*;
#(
  parameter int I_BITS = 12,
  parameter int Q_BITS = 12,
  parameter int P_BITS = out_max_w(I_BITS, Q_BITS)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic signed [I_BITS-1:0] xi,
  input  logic signed [Q_BITS-1:0] xq,
  input  logic                     in_valid,
  output logic                     out_valid,
  output logic        [P_BITS-1:0] power
);

  logic signed [P_BITS-1:0] xi_w;
  logic signed [P_BITS-1:0] xq_w;
  logic signed [P_BITS-1:0] ii;
  logic signed [P_BITS-1:0] qq;
  logic        [P_BITS-1:0] sum;

  assign xi_w = P_BITS'(xi);
  assign xq_w = P_BITS'(xq);
  assign ii   = xi_w * xi_w;
  assign qq   = xq_w * xq_w;
  // Both squares are non-negative, so the sum is
  // at most 2^(P_BITS-1) and never wraps.
  assign sum  = $unsigned(ii) + $unsigned(qq);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      out_valid <= 1'b0;
      power     <= '0;
    end else begin
      out_valid <= in_valid;
      power     <= sum;
    end
  end

endmodule

// File: rtl/arg_max_frame.sv
// Streaming per-frame argmax of I^2+Q^2 with buffered results.
// Optional threshold detect output via ARG_MAX_THRESHOLD_EN.
module arg_max_frame
  import arg_max_pkg::*;
#(
  parameter int I_BITS       = 12,
  parameter int Q_BITS       = 12,
  parameter int LENGTH       = 1024,
  parameter int INDEX_BITS   = index_w(LENGTH),
  parameter int OUT_MAX_BITS = out_max_w(I_BITS, Q_BITS)
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic signed [I_BITS-1:0] xi,
  input  logic signed [Q_BITS-1:0] xq,
  input  logic                     m_axis_tvalid,
  output logic                     s_axis_tready,
  output logic                     s_axis_tvalid,
  input  logic                     m_axis_tready,
`ifdef ARG_MAX_THRESHOLD_EN
  input  logic [OUT_MAX_BITS-1:0]  threshold,
  output logic                     detect,
`endif
  output logic [OUT_MAX_BITS-1:0]  out_max,
  output logic [INDEX_BITS-1:0]    index
);

  typedef struct packed {
    logic [OUT_MAX_BITS-1:0] out_max;
    logic [INDEX_BITS-1:0]   index;
`ifdef ARG_MAX_THRESHOLD_EN
    logic                    detect;
`endif
  } res_t;

  localparam logic [INDEX_BITS-1:0] LAST =
    INDEX_BITS'(LENGTH - 1);

  logic                    accept;
  logic                    s1_valid;
  logic [OUT_MAX_BITS-1:0] s1_power;

  logic [INDEX_BITS-1:0]   cnt;
  logic [OUT_MAX_BITS-1:0] run_max;
  logic [INDEX_BITS-1:0]   run_idx;
  logic                    take;
  logic                    last;

  logic                    done_v;
  logic [OUT_MAX_BITS-1:0] done_max;
  logic [INDEX_BITS-1:0]   done_idx;
  res_t                    new_res;

  logic                    out_v, out_v_n;
  res_t                    out_res, out_n;
  logic                    pend_v, pend_v_n;
  res_t                    pend_res, pend_n;
  logic                    ready_q;

  assign accept = m_axis_tvalid && ready_q;

  arg_max_power #(
    .I_BITS (I_BITS),
    .Q_BITS (Q_BITS),
    .P_BITS (OUT_MAX_BITS)
  ) u_power (
    .clk       (clk),
    .n_rst     (n_rst),
    .xi        (xi),
    .xq        (xq),
    .in_valid  (accept),
    .out_valid (s1_valid),
    .power     (s1_power)
  );

  // First sample of a frame loads unconditionally; ties keep earliest.
  assign take = (cnt == '0) || (s1_power > run_max);
  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt      <= '0;
      run_max  <= '0;
      run_idx  <= '0;
      done_v   <= 1'b0;
      done_max <= '0;
      done_idx <= '0;
    end else begin
      done_v <= s1_valid && last;
      if (s1_valid) begin
        if (take) begin
          run_max <= s1_power;
          run_idx <= cnt;
        end
        done_max <= take ? s1_power : run_max;
        done_idx <= take ? cnt : run_idx;
        cnt      <= last ? '0 : cnt + INDEX_BITS'(1);
      end
    end
  end

  always_comb begin
    new_res         = '0;
    new_res.out_max = done_max;
    new_res.index   = done_idx;
`ifdef ARG_MAX_THRESHOLD_EN
    new_res.detect  = done_max > threshold;
`endif
  end

  // Output register drains first; pending holds one overflow result.
  always_comb begin
    out_v_n  = out_v;
    out_n    = out_res;
    pend_v_n = pend_v;
    pend_n   = pend_res;
    if (!out_v || m_axis_tready) begin
      if (pend_v) begin
        out_v_n  = 1'b1;
        out_n    = pend_res;
        pend_v_n = done_v;
        if (done_v) pend_n = new_res;
      end else begin
        out_v_n = done_v;
        if (done_v) out_n = new_res;
      end
    end else if (done_v) begin
      pend_v_n = 1'b1;
      pend_n   = new_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      out_v    <= 1'b0;
      out_res  <= '0;
      pend_v   <= 1'b0;
      pend_res <= '0;
      ready_q  <= 1'b0;
    end else begin
      out_v    <= out_v_n;
      out_res  <= out_n;
      pend_v   <= pend_v_n;
      pend_res <= pend_n;
      ready_q  <= !pend_v_n;
    end
  end

  assign s_axis_tready = ready_q;
  assign s_axis_tvalid = out_v;
  assign out_max       = out_res.out_max;
  assign index         = out_res.index;
`ifdef ARG_MAX_THRESHOLD_EN
  assign detect        = out_res.detect;
`endif

endmodule
